mem_access_ctrl: RTL

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// Memory access controller: turns a single-cycle request from the control
// unit into a MOV/MOC four-phase handshake with the RAM. Misaligned requests
// are refused with a one-cycle pulse. A RAM that never answers is released
// after TIMEOUT cycles.
//
// RAM handshake: MOV is raised with the address, data, direction and size
// already stable. The RAM raises MOC when the access is complete, and read
// data is valid on DataOut while MOC is high. MOV is then dropped and MOCoff
// raised. The controller waits for MOC to fall before finishing. The latched
// bus values stay stable until the controller is back in IDLE.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        req_rw,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        align_fault,
  output logic        timeout,
  output logic        MOV,
  output logic        ReadWrite,
  output logic [2:0]  MS_2_0,
  output logic [31:0] Address,
  output logic [31:0] DataIn,
  output logic        MOCoff,
  input  logic        MOC,
  input  logic [31:0] DataOut,
  output logic [1:0]  state_dbg
);

  localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RELEASE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t      state, state_d;
  logic [7:0]  cnt, cnt_d;
  logic        to_flag, to_flag_d;
  logic        rw_d;
  logic [2:0]  ms_d;
  logic [31:0] addr_d, wdata_d, rdata_d;
  logic        fault_d;
  logic        misaligned;

  assign state_dbg = state;

  // Alignment rule: halfwords on even addresses, words on multiples of four.
  // Size code 11 is reserved and always refused.
  assign misaligned = (req_size[1:0] == 2'b11) ||
                      ((req_size[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_size[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

  // Next-state and next-register values; requests only matter in IDLE.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    to_flag_d = to_flag;
    rw_d      = ReadWrite;
    ms_d      = MS_2_0;
    addr_d    = Address;
    wdata_d   = DataIn;
    rdata_d   = rdata;
    fault_d   = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (misaligned) begin
            fault_d = 1'b1;
          end else begin
            rw_d      = req_rw;
            ms_d      = req_size;
            addr_d    = req_addr;
            wdata_d   = req_wdata;
            cnt_d     = 8'd0;
            to_flag_d = 1'b0;
            state_d   = WAIT;
          end
        end
      end
      WAIT: begin
        if (MOC) begin
          state_d = RELEASE;
          if (ReadWrite) rdata_d = DataOut;
        end else if ((cnt + 8'd1) == TO_LIM) begin
          cnt_d     = cnt + 8'd1;
          to_flag_d = 1'b1;
          state_d   = RELEASE;
        end else begin
          cnt_d = cnt + 8'd1;
        end
      end
      RELEASE: begin
        if (!MOC) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, latched bus and registered outputs derived from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= 8'd0;
      to_flag     <= 1'b0;
      ReadWrite   <= 1'b1;
      MS_2_0      <= 3'd0;
      Address     <= 32'd0;
      DataIn      <= 32'd0;
      rdata       <= 32'd0;
      MOV         <= 1'b0;
      MOCoff      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      align_fault <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      to_flag     <= to_flag_d;
      ReadWrite   <= rw_d;
      MS_2_0      <= ms_d;
      Address     <= addr_d;
      DataIn      <= wdata_d;
      rdata       <= rdata_d;
      MOV         <= (state_d == WAIT);
      MOCoff      <= (state_d == RELEASE);
      busy        <= (state_d != IDLE);
      done        <= (state_d == DONE);
      timeout     <= (state_d == DONE) && to_flag_d;
      align_fault <= fault_d;
    end
  end

endmodule
